// File: rtl/mcu_router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mcu_router_pkg                                               |
// | Description : Shared types and constants for the MCU command router:       |
// |               frame state encoding, local command codes and a small        |
// |               helper that classifies router-local target codes.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mcu_router_pkg;

  // Frame state; the explicit width keeps the encoding stable across tools
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    FWD   = 3'd2,
    LOCAL = 3'd3,
    DROP  = 3'd4
  } state_t;

  localparam logic [7:0] TGT_STATUS  = 8'hF0;  // read pending / rr index / timeout flag
  localparam logic [7:0] TGT_ENABLE  = 8'hF1;  // write interrupt enable mask
  localparam logic [7:0] RR_NONE     = 8'hFF;  // no interrupt pending, also DROP filler
  localparam int         MAX_TARGETS = 8;

  // True for target codes handled inside the router rather than forwarded
  function automatic logic is_local(input logic [7:0] code);
    return (code == TGT_STATUS) || (code == TGT_ENABLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_cmd_router_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_pick                                                      |
// | Description : Combinational circular priority encoder. Returns the first   |
// |               set request at or after ptr_i, wrapping at NUM_TARGETS.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_TARGETS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_TARGETS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic                   valid_o,
  output logic [IDX_W-1:0]       idx_o
);

  // One extra bit so ptr + offset never overflows before the wrap
  logic [IDX_W:0] cand;

  // Walk offsets 0..N-1 from the pointer; the first hit wins
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_TARGETS)) begin
        cand = cand - (IDX_W+1)'(NUM_TARGETS);
      end
      if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mcu_cmd_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mcu_cmd_router                                               |
// | Description : Shares the MCU SPI byte channel among NUM_TARGETS clients.   |
// |               The first byte of a frame selects a client (or a local       |
// |               status/enable command); the rest is re-framed and forwarded. |
// |               The selected client's return byte goes back to the MCU and   |
// |               client interrupts are merged into int_out_n.                 |
// |               Optional build macro MCU_ROUTER_TIMEOUT_EN adds an           |
// |               inter-byte timeout that abandons stale frames.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mcu_cmd_router
  import mcu_router_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int TMO_W       = 24,
  parameter int TMO_CYCLES  = 8000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_in_strobe,
  input  logic                     data_in_start,
  input  logic [7:0]               data_in,
  output logic [7:0]               data_out,
  output logic                     int_out_n,
  output logic [NUM_TARGETS-1:0]   tgt_strobe,
  output logic                     tgt_start,
  output logic [7:0]               tgt_data,
  input  logic [8*NUM_TARGETS-1:0] tgt_data_out,
  input  logic [NUM_TARGETS-1:0]   tgt_int
);

  localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

  state_t                 state_q;
  logic [IDX_W-1:0]       tgt_q;         // selected client for SEL/FWD
  logic                   loc_enable_q;  // LOCAL frame is the enable-mask write
  logic [3:0]             k_q;           // byte index inside a LOCAL frame
  logic [7:0]             data_out_q;
  logic [NUM_TARGETS-1:0] tgt_strobe_q;
  logic                   tgt_start_q;
  logic [7:0]             tgt_data_q;
  logic [NUM_TARGETS-1:0] en_mask_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic                   tmo_flag_q;
  // Return capture runs one cycle behind the forwarded pulse so a client
  // that registers its reply on the strobe is still picked up.
  logic                   ret_pend_q;
  logic [IDX_W-1:0]       ret_idx_q;

  logic [NUM_TARGETS-1:0] pending;
  logic                   rr_valid;
  logic [IDX_W-1:0]       rr_idx;
  logic [IDX_W-1:0]       rr_next;
  logic                   tmo_hit;
  logic                   start_stb;
  logic [7:0]             tdo_bytes [NUM_TARGETS];

  // Split the flat client return bus into per-client bytes
  for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_tdo_unpack
    assign tdo_bytes[gi] = tgt_data_out[8*gi +: 8];
  end

  assign pending   = tgt_int & en_mask_q;
  assign int_out_n = ~|pending;
  assign start_stb = data_in_strobe & data_in_start;
  assign rr_next   = (rr_idx == IDX_W'(NUM_TARGETS - 1)) ? '0 : rr_idx + 1'b1;

  rr_pick #(
    .NUM_TARGETS (NUM_TARGETS),
    .IDX_W       (IDX_W)
  ) u_rr_pick (
    .req_i   (pending),
    .ptr_i   (rr_ptr_q),
    .valid_o (rr_valid),
    .idx_o   (rr_idx)
  );

`ifdef MCU_ROUTER_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q;

  // Count idle cycles of an open frame; any strobe restarts the count
  always_ff @(posedge clk) begin
    if (reset || (state_q == IDLE) || data_in_strobe) begin
      tmo_cnt_q <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q != IDLE) && !data_in_strobe && (tmo_cnt_q == TMO_LAST);
`else
  // Timeout parameters only matter in the timeout build
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = TMO_W[0] ^ TMO_CYCLES[0];
  assign tmo_hit        = 1'b0;
`endif

  // Frame FSM with registered forward pulses, return byte and local registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tgt_q        <= '0;
      loc_enable_q <= 1'b0;
      k_q          <= '0;
      data_out_q   <= 8'h00;
      tgt_strobe_q <= '0;
      tgt_start_q  <= 1'b0;
      tgt_data_q   <= 8'h00;
      en_mask_q    <= '1;
      rr_ptr_q     <= '0;
      tmo_flag_q   <= 1'b0;
      ret_pend_q   <= 1'b0;
      ret_idx_q    <= '0;
    end else begin
      tgt_strobe_q <= '0;
      tgt_start_q  <= 1'b0;
      ret_pend_q   <= |tgt_strobe_q;

      if (ret_pend_q) begin
        data_out_q <= tdo_bytes[ret_idx_q];
      end

      if (start_stb) begin
        // A start always opens a new frame, aborting whatever was open
        data_out_q   <= 8'h00;
        k_q          <= '0;
        tgt_q        <= data_in[IDX_W-1:0];
        loc_enable_q <= (data_in == TGT_ENABLE);
        if (data_in < 8'(NUM_TARGETS)) begin
          state_q <= SEL;
        end else if (is_local(data_in)) begin
          state_q <= LOCAL;
        end else begin
          state_q <= DROP;
        end
      end else if (tmo_hit) begin
        state_q    <= IDLE;
        tmo_flag_q <= 1'b1;
      end else if (data_in_strobe) begin
        case (state_q)
          SEL, FWD: begin
            tgt_strobe_q <= NUM_TARGETS'(1) << tgt_q;
            tgt_start_q  <= (state_q == SEL);
            tgt_data_q   <= data_in;
            ret_idx_q    <= tgt_q;
            state_q      <= FWD;
          end
          LOCAL: begin
            if (k_q != 4'd15) begin
              k_q <= k_q + 4'd1;
            end
            if (loc_enable_q) begin
              data_out_q <= 8'h00;
              if (k_q == 4'd0) begin
                en_mask_q <= data_in[NUM_TARGETS-1:0];
              end
            end else begin
              case (k_q)
                4'd0: data_out_q <= 8'(pending);
                4'd1: begin
                  if (rr_valid) begin
                    data_out_q <= 8'(rr_idx);
                    rr_ptr_q   <= rr_next;
                  end else begin
                    data_out_q <= RR_NONE;
                  end
                end
                4'd2: begin
                  data_out_q <= {tmo_flag_q, 7'd0};
                  tmo_flag_q <= 1'b0;
                end
                default: data_out_q <= 8'h00;
              endcase
            end
          end
          DROP: begin
            data_out_q <= RR_NONE;
          end
          default: begin
            // IDLE: stray data bytes are ignored
          end
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign tgt_strobe = tgt_strobe_q;
  assign tgt_start  = tgt_start_q;
  assign tgt_data   = tgt_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mcu_cmd_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mcu_cmd_router                                            |
// | Description : Self-checking bench for mcu_cmd_router: directed scenarios   |
// |               plus random frames checked against a behavioural model.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mcu_cmd_router;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           data_in_strobe;
  logic           data_in_start;
  logic [7:0]     data_in;
  logic [7:0]     data_out;
  logic           int_out_n;
  logic [N-1:0]   tgt_strobe;
  logic           tgt_start;
  logic [7:0]     tgt_data;
  logic [8*N-1:0] tgt_data_out;
  logic [N-1:0]   tgt_int;

  int total = 0;
  int bad   = 0;

  // Observations captured by send()
  logic [N-1:0] o_stb, o_stb_late;
  logic         o_start, o_intn;
  logic [7:0]   o_tdata, o_dout;

  // Behavioural model state
  localparam int K_IDLE = 0, K_FWD = 1, K_STAT = 2, K_EN = 3, K_DROP = 4;
  int           m_kind, m_tgt, m_k, m_rr;
  bit           m_first, m_tmo;
  logic [N-1:0] m_en;
  logic [7:0]   m_dout;
  logic [N-1:0] e_stb;
  logic         e_start;
  logic [7:0]   e_tdata;

  mcu_cmd_router #(
    .NUM_TARGETS (N),
    .TMO_W       (24),
    .TMO_CYCLES  (100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in_strobe (data_in_strobe),
    .data_in_start  (data_in_start),
    .data_in        (data_in),
    .data_out       (data_out),
    .int_out_n      (int_out_n),
    .tgt_strobe     (tgt_strobe),
    .tgt_start      (tgt_start),
    .tgt_data       (tgt_data),
    .tgt_data_out   (tgt_data_out),
    .tgt_int        (tgt_int)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_kind = K_IDLE; m_tgt = 0; m_k = 0; m_rr = 0;
    m_first = 1'b0; m_tmo = 1'b0; m_en = '1; m_dout = 8'h00;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; data_in_strobe = 1'b0; data_in_start = 1'b0; data_in = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One MCU byte, 4 clk per byte; a strobed client answers with resp
  task automatic send(input logic st, input logic [7:0] d, input logic [7:0] resp);
    @(negedge clk);
    data_in_strobe = 1'b1; data_in_start = st; data_in = d;
    @(negedge clk);
    data_in_strobe = 1'b0; data_in_start = 1'b0;
    o_stb = tgt_strobe; o_start = tgt_start; o_tdata = tgt_data;
    for (int i = 0; i < N; i++) if (tgt_strobe[i]) tgt_data_out[8*i +: 8] = resp;
    @(negedge clk);
    o_stb_late = tgt_strobe;
    @(negedge clk);
    @(negedge clk);
    o_dout = data_out; o_intn = int_out_n;
  endtask

  function automatic int first_pending(input logic [N-1:0] pend, input int ptr);
    for (int i = 0; i < N; i++) if (pend[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // Expected effect of one byte, straight from the frame rules
  task automatic model_byte(input logic st, input logic [7:0] d, input logic [7:0] resp);
    int idx;
    e_stb = '0; e_start = 1'b0; e_tdata = 8'h00;
    if (st) begin
      m_k = 0; m_first = 1'b1; m_dout = 8'h00;
      if (d < N) begin m_kind = K_FWD; m_tgt = int'(d); end
      else if (d == 8'hF0) m_kind = K_STAT;
      else if (d == 8'hF1) m_kind = K_EN;
      else m_kind = K_DROP;
    end else begin
      case (m_kind)
        K_FWD: begin
          e_stb = N'(1) << m_tgt; e_start = m_first; e_tdata = d;
          m_first = 1'b0; m_dout = resp;
        end
        K_STAT: begin
          if (m_k == 0) m_dout = 8'(tgt_int & m_en);
          else if (m_k == 1) begin
            idx = first_pending(tgt_int & m_en, m_rr);
            if (idx < 0) m_dout = 8'hFF;
            else begin m_dout = 8'(idx); m_rr = (idx + 1) % N; end
          end else if (m_k == 2) begin
            m_dout = m_tmo ? 8'h80 : 8'h00; m_tmo = 1'b0;
          end else m_dout = 8'h00;
          m_k++;
        end
        K_EN: begin
          if (m_k == 0) m_en = d[N-1:0];
          m_dout = 8'h00; m_k++;
        end
        K_DROP: m_dout = 8'hFF;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tgt_int = '0;
    @(negedge clk);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h want=00", data_out); end
    total++; if (tgt_strobe !== '0) begin bad++; $display("FAIL rst_stb got=%b want=0000", tgt_strobe); end
    total++; if (tgt_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b want=0", tgt_start); end
    total++; if (tgt_data !== 8'h00) begin bad++; $display("FAIL rst_tdata got=%h want=00", tgt_data); end
    total++; if (int_out_n !== 1'b1) begin bad++; $display("FAIL rst_intn_idle got=%b want=1", int_out_n); end
    tgt_int = 4'b1000;
    #1;
    total++; if (int_out_n !== 1'b0) begin bad++; $display("FAIL rst_enmask got=%b want=0", int_out_n); end
    tgt_int = '0;
  endtask

  task automatic test_forward();
    logic [7:0] fb [3] = '{8'h07, 8'h04, 8'h59};
    send(1'b1, 8'h01, 8'h00);
    total++; if (o_stb !== '0) begin bad++; $display("FAIL fwd_hdr_stb got=%b want=0000", o_stb); end
    total++; if (o_dout !== 8'h00) begin bad++; $display("FAIL fwd_hdr_dout got=%h want=00", o_dout); end
    for (int i = 0; i < 3; i++) begin
      send(1'b0, fb[i], 8'h90 + 8'(i));
      total++; if (o_stb !== 4'b0010) begin bad++; $display("FAIL fwd_stb[%0d] got=%b want=0010", i, o_stb); end
      total++; if (o_start !== (i == 0)) begin bad++; $display("FAIL fwd_start[%0d] got=%b want=%b", i, o_start, i == 0); end
      total++; if (o_tdata !== fb[i]) begin bad++; $display("FAIL fwd_data[%0d] got=%h want=%h", i, o_tdata, fb[i]); end
      total++; if (o_stb_late !== '0) begin bad++; $display("FAIL fwd_pulse[%0d] got=%b want=0000", i, o_stb_late); end
    end
  endtask

  task automatic test_return();
    tgt_data_out = 32'h44332211;
    send(1'b1, 8'h01, 8'h00);
    send(1'b0, 8'h10, 8'h5C);
    total++; if (o_dout !== 8'h5C) begin bad++; $display("FAIL ret_t1 got=%h want=5c", o_dout); end
    send(1'b1, 8'h03, 8'h00);
    total++; if (o_dout !== 8'h00) begin bad++; $display("FAIL ret_start_clr got=%h want=00", o_dout); end
    send(1'b0, 8'h20, 8'hA7);
    total++; if (o_dout !== 8'hA7) begin bad++; $display("FAIL ret_t3 got=%h want=a7", o_dout); end
  endtask

  task automatic test_interrupts();
    logic [7:0] exp1 [4] = '{8'h0A, 8'h01, 8'h00, 8'h00};
    tgt_int = 4'b1010;
    @(negedge clk);
    total++; if (int_out_n !== 1'b0) begin bad++; $display("FAIL int_n got=%b want=0", int_out_n); end
    send(1'b1, 8'hF0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 8'h00, 8'h00);
      total++; if (o_dout !== exp1[i]) begin bad++; $display("FAIL stat_b%0d got=%h want=%h", i, o_dout, exp1[i]); end
    end
    send(1'b1, 8'hF0, 8'h00);
    send(1'b0, 8'h00, 8'h00);
    total++; if (o_dout !== 8'h0A) begin bad++; $display("FAIL stat2_pend got=%h want=0a", o_dout); end
    send(1'b0, 8'h00, 8'h00);
    total++; if (o_dout !== 8'h03) begin bad++; $display("FAIL stat2_rr got=%h want=03", o_dout); end
    send(1'b1, 8'hF1, 8'h00);
    send(1'b0, 8'h01, 8'h00);
    total++; if (o_intn !== 1'b1) begin bad++; $display("FAIL en_mask_intn got=%b want=1", o_intn); end
    send(1'b1, 8'hF0, 8'h00);
    send(1'b0, 8'h00, 8'h00);
    total++; if (o_dout !== 8'h00) begin bad++; $display("FAIL masked_pend got=%h want=00", o_dout); end
    send(1'b0, 8'h00, 8'h00);
    total++; if (o_dout !== 8'hFF) begin bad++; $display("FAIL masked_rr got=%h want=ff", o_dout); end
    send(1'b1, 8'hF1, 8'h00);
    send(1'b0, 8'h0F, 8'h00);
    total++; if (o_intn !== 1'b0) begin bad++; $display("FAIL en_restore got=%b want=0", o_intn); end
    tgt_int = '0;
  endtask

  task automatic test_abort_drop();
    send(1'b1, 8'h00, 8'h00);
    send(1'b0, 8'h11, 8'h21);
    total++; if (o_stb !== 4'b0001) begin bad++; $display("FAIL abort_t0 got=%b want=0001", o_stb); end
    send(1'b1, 8'h02, 8'h00);
    total++; if (o_stb !== '0) begin bad++; $display("FAIL abort_hdr got=%b want=0000", o_stb); end
    send(1'b0, 8'h22, 8'h23);
    total++; if (o_stb !== 4'b0100) begin bad++; $display("FAIL abort_t2 got=%b want=0100", o_stb); end
    total++; if (o_start !== 1'b1) begin bad++; $display("FAIL abort_t2_start got=%b want=1", o_start); end
    send(1'b1, 8'h09, 8'h00);
    total++; if (o_dout !== 8'h00) begin bad++; $display("FAIL drop_hdr got=%h want=00", o_dout); end
    send(1'b0, 8'h33, 8'h00);
    total++; if (o_stb !== '0) begin bad++; $display("FAIL drop_stb got=%b want=0000", o_stb); end
    total++; if (o_dout !== 8'hFF) begin bad++; $display("FAIL drop_dout got=%h want=ff", o_dout); end
  endtask

  task automatic test_reset_midframe();
    send(1'b1, 8'h01, 8'h00);
    send(1'b0, 8'h55, 8'h3C);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_rst_dout got=%h want=00", data_out); end
    total++; if (tgt_data !== 8'h00) begin bad++; $display("FAIL mid_rst_tdata got=%h want=00", tgt_data); end
    total++; if (tgt_strobe !== '0 || tgt_start !== 1'b0) begin
      bad++; $display("FAIL mid_rst_stb got=%b/%b want=0000/0", tgt_strobe, tgt_start);
    end
    reset = 1'b0;
    model_reset();
    send(1'b0, 8'h66, 8'h77);
    total++; if (o_stb !== '0) begin bad++; $display("FAIL mid_rst_ignore got=%b want=0000", o_stb); end
    total++; if (o_dout !== 8'h00) begin bad++; $display("FAIL mid_rst_ignore_dout got=%h want=00", o_dout); end
  endtask

  task automatic test_random();
    logic       st;
    logic [7:0] d, r;
    int         pick;
    apply_reset();
    tgt_int = '0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) tgt_int = N'($urandom);
      st = ($urandom_range(0, 3) == 0);
      if (st) begin
        pick = $urandom_range(0, 7);
        if (pick < 4) d = 8'(pick);
        else if (pick < 6) d = 8'hF0;
        else if (pick == 6) d = 8'hF1;
        else d = 8'($urandom);
      end else d = 8'($urandom);
      r = 8'($urandom);
      send(st, d, r);
      model_byte(st, d, r);
      total++; if (o_stb !== e_stb) begin bad++; $display("FAIL rnd_stb n=%0d got=%b want=%b", n, o_stb, e_stb); end
      if (e_stb != '0) begin
        total++; if (o_start !== e_start) begin bad++; $display("FAIL rnd_start n=%0d got=%b want=%b", n, o_start, e_start); end
        total++; if (o_tdata !== e_tdata) begin bad++; $display("FAIL rnd_tdata n=%0d got=%h want=%h", n, o_tdata, e_tdata); end
      end
      total++; if (o_stb_late !== '0) begin bad++; $display("FAIL rnd_pulse n=%0d got=%b want=0000", n, o_stb_late); end
      total++; if (o_dout !== m_dout) begin bad++; $display("FAIL rnd_dout n=%0d got=%h want=%h", n, o_dout, m_dout); end
      total++; if (o_intn !== ~|(tgt_int & m_en)) begin
        bad++; $display("FAIL rnd_intn n=%0d got=%b want=%b", n, o_intn, ~|(tgt_int & m_en));
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    tgt_int = '0;
`ifdef MCU_ROUTER_TIMEOUT_EN
    send(1'b1, 8'h02, 8'h00);
    repeat (86) @(negedge clk);
    send(1'b0, 8'hAA, 8'h5A);
    total++; if (o_stb !== 4'b0100) begin bad++; $display("FAIL tmo_still_open got=%b want=0100", o_stb); end
    repeat (100) @(negedge clk);
    send(1'b0, 8'hBB, 8'h00);
    total++; if (o_stb !== '0) begin bad++; $display("FAIL tmo_closed got=%b want=0000", o_stb); end
    send(1'b1, 8'hF0, 8'h00);
    send(1'b0, 8'h00, 8'h00);
    send(1'b0, 8'h00, 8'h00);
    send(1'b0, 8'h00, 8'h00);
    total++; if (o_dout !== 8'h80) begin bad++; $display("FAIL tmo_flag got=%h want=80", o_dout); end
    send(1'b1, 8'hF0, 8'h00);
    send(1'b0, 8'h00, 8'h00);
    send(1'b0, 8'h00, 8'h00);
    send(1'b0, 8'h00, 8'h00);
    total++; if (o_dout !== 8'h00) begin bad++; $display("FAIL tmo_flag_clr got=%h want=00", o_dout); end
`else
    send(1'b1, 8'h02, 8'h00);
    repeat (200) @(negedge clk);
    send(1'b0, 8'hAA, 8'h5A);
    total++; if (o_stb !== 4'b0100) begin bad++; $display("FAIL notmo_open got=%b want=0100", o_stb); end
    send(1'b1, 8'hF0, 8'h00);
    send(1'b0, 8'h00, 8'h00);
    send(1'b0, 8'h00, 8'h00);
    send(1'b0, 8'h00, 8'h00);
    total++; if (o_dout !== 8'h00) begin bad++; $display("FAIL notmo_flag got=%h want=00", o_dout); end
`endif
  endtask

  initial begin
    reset = 1'b1; data_in_strobe = 1'b0; data_in_start = 1'b0; data_in = 8'h00;
    tgt_data_out = '0; tgt_int = '0;
    test_reset();
    test_forward();
    test_return();
    test_interrupts();
    test_abort_drop();
    test_reset_midframe();
    test_random();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
